// File: rtl/fifo_reader.sv
// Streams words out of a registered-read FIFO into a valid/ready interface.
// A 2-entry skid buffer plus one in-flight read allow one word per cycle without overflow.
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  empty,
   output logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t                  occ, occ_nxt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head_q, head_nxt;
   logic [DATA_WIDTH-1:0] tail_q, tail_nxt;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  pop;
   logic                  capture;
   logic [2:0]            credits;

   // The FIFO word returns exactly one cycle after its strobe and must be taken then.
   assign capture   = inflight;
   assign out_valid = ~rst & (occ != EMPTY);
   assign out_data  = rst ? '0 : head_q;
   assign rd_count  = rst ? '0 : cnt_q;
   assign pop       = out_valid & out_ready;

   // Free slots, counting the word already on its way and the slot a pop frees this cycle.
   assign credits = 3'd2 - {1'b0, occ} - {2'b0, inflight} + {2'b0, pop};
   assign r_en    = en & ~empty & ~rst & (credits != 3'd0);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      occ_nxt  = occ;
      head_nxt = head_q;
      tail_nxt = tail_q;
      case (occ)
         EMPTY: begin
            if (capture) begin
               head_nxt = data_out;
               occ_nxt  = ONE;
            end
         end
         ONE: begin
            if (capture && pop) begin
               head_nxt = data_out;
            end else if (capture) begin
               tail_nxt = data_out;
               occ_nxt  = TWO;
            end else if (pop) begin
               occ_nxt = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               head_nxt = tail_q;
               occ_nxt  = ONE;
               if (capture) begin
                  tail_nxt = data_out;
                  occ_nxt  = TWO;
               end
            end
         end
         default: occ_nxt = EMPTY;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   // NOTE: the data registers are reset too, so out_data reads zero rather than stale words.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= EMPTY;
         inflight <= 1'b0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
      end else begin
         occ      <= occ_nxt;
         inflight <= r_en;
         head_q   <= head_nxt;
         tail_q   <= tail_nxt;
         if (pop) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // Simulation-only guards: the credit scheme must keep these states unreachable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(occ == TWO && capture && pop));
         assert (({1'b0, occ} + {2'b0, inflight}) <= 3'd2);
      end
   end

endmodule
